// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a debounced push-button level into single-clock control events for
// the clock-setting logic: press, release, long-press, and auto-repeat.
// Tick-based timing: all hold and repeat intervals count `tick` strobes.
//
// Optional build macro: BTN_EVT_ACCEL_EN
//   When defined, a 3-bit saturating repeat counter shortens the repeat
//   interval to max(REPEAT_TICKS>>2, 1) after the fourth repeat of a hold.
//
// The release and repeat events are exposed as release_evt / repeat_evt
// because `release` and `repeat` are reserved words in SystemVerilog.
//
// Handshake: none. btn and tick are sampled every clk. Every event output is
// a registered one-clk pulse that appears in the cycle after the sampling edge.
// At most one event pulse is high in any cycle.

module button_event_decoder #(
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 150,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn,
  output logic       press,
  output logic       release_evt,
  output logic       long_press,
  output logic       repeat_evt,
  output logic       held,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  // Terminal counts: the event fires on the tick that finds cnt at N-1.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             press_d, release_d, long_d, repeat_d, held_d;
  logic [CNT_W-1:0] interval_last;

`ifdef BTN_EVT_ACCEL_EN
  localparam int               FAST_TICKS = ((REPEAT_TICKS >> 2) < 1) ? 1 : (REPEAT_TICKS >> 2);
  localparam logic [CNT_W-1:0] FAST_LAST  = CNT_W'(FAST_TICKS - 1);

  logic [2:0] rcnt_q, rcnt_d;

  // Fast scroll once four repeats have been issued in the current hold.
  assign interval_last = (rcnt_q >= 3'd4) ? FAST_LAST : REPEAT_LAST;
`else
  assign interval_last = REPEAT_LAST;
`endif

  assign state_dbg = state_q;

  // Next-state, counter and event decode; release has priority over any tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
`ifdef BTN_EVT_ACCEL_EN
    rcnt_d    = rcnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Counter is parked at zero; a tick on the press edge is not counted.
        cnt_d = '0;
        if (btn && !btn_q) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (!btn) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (tick && (cnt_q == LONG_LAST)) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
`ifdef BTN_EVT_ACCEL_EN
          rcnt_d  = 3'd0;
`endif
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (tick && (cnt_q == interval_last)) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
`ifdef BTN_EVT_ACCEL_EN
          rcnt_d   = (rcnt_q == 3'd7) ? rcnt_q : rcnt_q + 3'd1;
`endif
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef BTN_EVT_ACCEL_EN
    if (state_d == IDLE) begin
      rcnt_d = 3'd0;
    end
`endif
    held_d = (state_d != IDLE);
  end

  // State, counter, input sample and registered outputs; reset aborts silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_q       <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_q       <= btn;
      press       <= press_d;
      release_evt <= release_d;
      long_press  <= long_d;
      repeat_evt  <= repeat_d;
      held        <= held_d;
    end
  end

`ifdef BTN_EVT_ACCEL_EN
  // Repeat counter for the accelerated scroll rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= 3'd0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with LONG_TICKS=4, REPEAT_TICKS=2, CNT_W=8.
// Each directed step pushes the expected post-edge output vector
// {state, press, release, long_press, repeat, held} and pops/compares it
// one time unit after the clock edge.

module tb_button_event_decoder;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_P = 2'd1;
  localparam logic [1:0] S_H = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       btn;
  logic       press;
  logic       release_evt;
  logic       long_press;
  logic       repeat_evt;
  logic       held;
  logic [1:0] state_dbg;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_q[$];

  button_event_decoder #(
    .LONG_TICKS  (4),
    .REPEAT_TICKS(2),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn        (btn),
    .press      (press),
    .release_evt(release_evt),
    .long_press (long_press),
    .repeat_evt (repeat_evt),
    .held       (held),
    .state_dbg  (state_dbg)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  function automatic logic [6:0] ev(input logic [1:0] s, input logic p, input logic r,
                                    input logic l, input logic rp);
    return {s, p, r, l, rp, (s != S_I)};
  endfunction

  task automatic compare(input string tag);
    logic [6:0] exp_v;
    logic [6:0] obs_v;
    exp_v = exp_q.pop_front();
    obs_v = {state_dbg, press, release_evt, long_press, repeat_evt, held};
    checks++;
    assert (obs_v === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b (state,press,rel,long,rep,held) t=%0t",
             tag, obs_v, exp_v, $time);
    end
  endtask

  // Drive one cycle of inputs, then check the outputs registered at that edge.
  task automatic step(input logic b, input logic t, input logic [6:0] e, input string tag);
    btn  = b;
    tick = t;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic check_now(input logic [6:0] e, input string tag);
    exp_q.push_back(e);
    compare(tag);
  endtask

  initial begin
    rst  = 1'b1;
    btn  = 1'b0;
    tick = 1'b0;
    #2;
    check_now(ev(S_I, 0, 0, 0, 0), "reset_state");
    rst = 1'b0;
    step(0, 1, ev(S_I, 0, 0, 0, 0), "idle_0");
    step(0, 1, ev(S_I, 0, 0, 0, 0), "idle_1");

    // Short press: 3 high samples then low.
    step(1, 1, ev(S_P, 1, 0, 0, 0), "short_press");
    step(1, 1, ev(S_P, 0, 0, 0, 0), "short_hold_1");
    step(1, 1, ev(S_P, 0, 0, 0, 0), "short_hold_2");
    step(0, 1, ev(S_I, 0, 1, 0, 0), "short_release");
    step(0, 1, ev(S_I, 0, 0, 0, 0), "short_idle");

    // Long hold: 12 high samples; long_press 4 clks after press, repeat every 2.
    for (int i = 0; i < 12; i++) begin
      step(1, 1, ev((i < 4) ? S_P : S_H, (i == 0), 0, (i == 4), (i >= 6) && (i % 2 == 0)),
           "long_hold");
    end
    step(0, 1, ev(S_I, 0, 1, 0, 0), "long_release");
    step(0, 1, ev(S_I, 0, 0, 0, 0), "long_idle");

    // Release collides with the terminal tick in PRESSED.
    step(1, 1, ev(S_P, 1, 0, 0, 0), "coll_press");
    step(1, 1, ev(S_P, 0, 0, 0, 0), "coll_hold_1");
    step(1, 1, ev(S_P, 0, 0, 0, 0), "coll_hold_2");
    step(1, 1, ev(S_P, 0, 0, 0, 0), "coll_hold_3");
    step(0, 1, ev(S_I, 0, 1, 0, 0), "coll_release");
    step(0, 1, ev(S_I, 0, 0, 0, 0), "coll_idle");

    // Sparse tick every 5th clk; the tick on the press edge is ignored.
    // The release at j=30 coincides with a repeat-terminal tick in HELD.
    for (int j = 0; j < 30; j++) begin
      step(1, (j % 5 == 0), ev((j < 20) ? S_P : S_H, (j == 0), 0, (j == 20), 0), "sparse_hold");
    end
    step(0, 1, ev(S_I, 0, 1, 0, 0), "sparse_release");
    step(0, 0, ev(S_I, 0, 0, 0, 0), "sparse_idle");

    // Reset while in HELD with the button still down.
    for (int i = 0; i < 6; i++) begin
      step(1, 1, ev((i < 4) ? S_P : S_H, (i == 0), 0, (i == 4), 0), "pre_rst_hold");
    end
    rst = 1'b1;
    #1;
    check_now(ev(S_I, 0, 0, 0, 0), "rst_async_clear");
    step(1, 1, ev(S_I, 0, 0, 0, 0), "rst_held");
    rst = 1'b0;
    step(1, 1, ev(S_P, 1, 0, 0, 0), "rst_fresh_press");
    step(1, 1, ev(S_P, 0, 0, 0, 0), "rst_fresh_hold");
    step(0, 1, ev(S_I, 0, 1, 0, 0), "rst_fresh_release");
    step(0, 1, ev(S_I, 0, 0, 0, 0), "rst_fresh_idle");

    // One-clk low glitch: release, then a new press.
    step(1, 1, ev(S_P, 1, 0, 0, 0), "glitch_press");
    step(1, 1, ev(S_P, 0, 0, 0, 0), "glitch_hold");
    step(0, 1, ev(S_I, 0, 1, 0, 0), "glitch_release");
    step(1, 1, ev(S_P, 1, 0, 0, 0), "glitch_repress");
    step(0, 1, ev(S_I, 0, 1, 0, 0), "glitch_release_2");
    step(0, 1, ev(S_I, 0, 0, 0, 0), "glitch_idle");

`ifdef BTN_EVT_ACCEL_EN
    // Accelerated scroll: after 4 repeats the interval drops to 1 tick.
    // A second hold checks that the spacing restarts slow.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        step(1, 1, ev((i < 4) ? S_P : S_H, (i == 0), 0, (i == 4),
                      (i >= 6) && ((i % 2 == 0) || (i >= 13))), "accel_hold");
      end
      step(0, 1, ev(S_I, 0, 1, 0, 0), "accel_release");
      step(0, 1, ev(S_I, 0, 0, 0, 0), "accel_idle");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
